// File: rtl/bsg_mem_pkg.sv
// Shared types and helpers for the 1R1W synchronous memory and its clear controller.
package bsg_mem_pkg;

    typedef enum logic {
        e_mem_clear = 1'b0,
        e_mem_ready = 1'b1
    } mem_state_e;

    // Address width that never collapses to zero bits, even for two-entry arrays.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_mem_clear_ctrl.sv
// Clear sequencer: zeroes every word once after reset, then reports the array as ready.
module bsg_mem_clear_ctrl
    import bsg_mem_pkg::*;
#(
    parameter int els_p = 2,
    localparam int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     clr_en_o,
    output logic [addr_width_lp-1:0] clr_addr_o,
    output logic                     ready_o,
    output mem_state_e               state_o
);

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    mem_state_e               state_q;
    logic [addr_width_lp-1:0] clr_cnt_q;
    logic                     ready_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_mem_clear;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                e_mem_clear: begin
                    if (clr_cnt_q == last_addr_lp) begin
                        state_q <= e_mem_ready;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                e_mem_ready: begin
                    state_q <= e_mem_ready;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= e_mem_clear;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en_o   = (state_q == e_mem_clear);
    assign clr_addr_o = clr_cnt_q;
    assign ready_o    = ready_q;
    assign state_o    = state_q;

endmodule

// File: rtl/bsg_mem_1r1w_sync_synth.sv
// One-read one-write synchronous memory with self-clearing after reset and registered read.
// Define BSG_MEM_1R1W_WMASK_EN to add the per-bit write mask port w_mask_i.
module bsg_mem_1r1w_sync_synth
    import bsg_mem_pkg::*;
#(
    parameter int width_p = 4,
    parameter int els_p = 2,
    parameter int read_write_same_addr_p = 0,
    localparam int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     ready_o,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
`ifdef BSG_MEM_1R1W_WMASK_EN
    input  logic [width_p-1:0]       w_mask_i,
`endif
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic                     r_v_o,
    output logic [width_p-1:0]       r_data_o
);

    localparam logic [addr_width_lp:0] els_lp = (addr_width_lp + 1)'(els_p);

    logic                     clr_en;
    logic [addr_width_lp-1:0] clr_addr;
    mem_state_e               ctrl_state;
    logic                     op_en;
    logic                     w_legal, r_legal, w_fire;
    logic [width_p-1:0]       wmask, w_merge;

    logic [width_p-1:0] mem_q [els_p];
    logic               r_v_q, r_v_d;
    logic [width_p-1:0] r_data_q, r_data_d;

    bsg_mem_clear_ctrl #(.els_p(els_p)) clear_ctrl (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clr_en_o  (clr_en),
        .clr_addr_o(clr_addr),
        .ready_o   (ready_o),
        .state_o   (ctrl_state)
    );

`ifdef BSG_MEM_1R1W_WMASK_EN
    assign wmask = w_mask_i;
`else
    assign wmask = '1;
`endif

    assign op_en   = (ctrl_state == e_mem_ready) && !reset_i;
    assign w_legal = ({1'b0, w_addr_i} < els_lp);
    assign r_legal = ({1'b0, r_addr_i} < els_lp);
    assign w_fire  = op_en && w_v_i && w_legal;
    assign w_merge = (w_legal ? (mem_q[w_addr_i] & ~wmask) : '0) | (w_data_i & wmask);

    // Clearing zeroes whole words regardless of the mask.
    always_ff @(posedge clk_i) begin
        if (clr_en) begin
            mem_q[clr_addr] <= '0;
        end else if (w_fire) begin
            mem_q[w_addr_i] <= w_merge;
        end
    end

    always_comb begin
        r_v_d    = 1'b0;
        r_data_d = r_data_q;
        if (op_en && r_v_i) begin
            r_v_d = 1'b1;
            if (!r_legal) begin
                r_data_d = '0;
            end else if ((read_write_same_addr_p != 0) && w_fire && (w_addr_i == r_addr_i)) begin
                r_data_d = w_merge;
            end else begin
                r_data_d = mem_q[r_addr_i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v_q    <= 1'b0;
            r_data_q <= '0;
        end else begin
            r_v_q    <= r_v_d;
            r_data_q <= r_data_d;
        end
    end

    assign r_v_o    = r_v_q;
    assign r_data_o = r_data_q;

`ifndef SYNTHESIS
    // Reports without stopping, so the defined drop/zero behaviour still takes effect.
    always_ff @(posedge clk_i) begin
        if (op_en) begin
            assert (!(w_v_i && !w_legal) && !(r_v_i && !r_legal))
            else $warning("bsg_mem_1r1w_sync_synth: access to address beyond els_p");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_synth.sv
// Directed bench: two 4-word instances (read-first and write-first) and a 3-word instance share stimulus.
module tb_bsg_mem_1r1w_sync_synth;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       w_v = 1'b0;
    logic       r_v = 1'b0;
    logic [1:0] w_addr = '0;
    logic [1:0] r_addr = '0;
    logic [3:0] w_data = '0;
`ifdef BSG_MEM_1R1W_WMASK_EN
    logic [3:0] w_mask = 4'hF;
`endif

    logic       rdy0, rv0, rdy1, rv1, rdy3, rv3;
    logic [3:0] rd0, rd1, rd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_mem_1r1w_sync_synth #(.width_p(4), .els_p(4), .read_write_same_addr_p(0)) dut_rf (
        .clk_i(clk), .reset_i(reset), .ready_o(rdy0),
        .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
`ifdef BSG_MEM_1R1W_WMASK_EN
        .w_mask_i(w_mask),
`endif
        .r_v_i(r_v), .r_addr_i(r_addr), .r_v_o(rv0), .r_data_o(rd0)
    );

    bsg_mem_1r1w_sync_synth #(.width_p(4), .els_p(4), .read_write_same_addr_p(1)) dut_wf (
        .clk_i(clk), .reset_i(reset), .ready_o(rdy1),
        .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
`ifdef BSG_MEM_1R1W_WMASK_EN
        .w_mask_i(w_mask),
`endif
        .r_v_i(r_v), .r_addr_i(r_addr), .r_v_o(rv1), .r_data_o(rd1)
    );

    bsg_mem_1r1w_sync_synth #(.width_p(4), .els_p(3), .read_write_same_addr_p(0)) dut_e3 (
        .clk_i(clk), .reset_i(reset), .ready_o(rdy3),
        .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
`ifdef BSG_MEM_1R1W_WMASK_EN
        .w_mask_i(w_mask),
`endif
        .r_v_i(r_v), .r_addr_i(r_addr), .r_v_o(rv3), .r_data_o(rd3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [3:0] d);
        w_v = 1'b1; w_addr = a; w_data = d; r_v = 1'b0;
        tick();
        w_v = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a);
        r_v = 1'b1; r_addr = a; w_v = 1'b0;
        tick();
        r_v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        check("reset_ready", rdy0, 0);
        check("reset_rv", rv0, 0);
        check("reset_rdata", rd0, 0);

        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("ready4_c%0d", i), rdy0, (i == 4));
            check($sformatf("ready3_c%0d", i), rdy3, (i >= 3));
        end

        for (int i = 0; i < 4; i++) begin
            do_read(2'(i));
            check($sformatf("init_rv_a%0d", i), rv0, 1);
            check($sformatf("init_rd_a%0d", i), rd0, 0);
            check($sformatf("init_rd_wf_a%0d", i), rd1, 0);
        end

        do_write(2'd2, 4'hA);
        check("idle_rv_after_write", rv0, 0);
        do_read(2'd2);
        check("wr_rd_rv", rv0, 1);
        check("wr_rd_data", rd0, 4'hA);
        tick();
        check("hold_rv", rv0, 0);
        check("hold_data", rd0, 4'hA);

        do_write(2'd1, 4'h3);
        w_v = 1'b1; w_addr = 2'd1; w_data = 4'hC;
        r_v = 1'b1; r_addr = 2'd1;
        tick();
        w_v = 1'b0; r_v = 1'b0;
        check("same_addr_read_first", rd0, 4'h3);
        check("same_addr_write_first", rd1, 4'hC);
        do_read(2'd1);
        check("same_addr_after_rf", rd0, 4'hC);
        check("same_addr_after_wf", rd1, 4'hC);

        w_v = 1'b1; w_addr = 2'd0; w_data = 4'h5;
        r_v = 1'b1; r_addr = 2'd2;
        tick();
        w_v = 1'b0; r_v = 1'b0;
        check("diff_addr_rd_rf", rd0, 4'hA);
        check("diff_addr_rd_wf", rd1, 4'hA);
        do_read(2'd0);
        check("diff_addr_wr", rd0, 4'h5);

        do_write(2'd3, 4'h7);
        do_read(2'd0);
        check("e3_keep_a0", rd3, 4'h5);
        do_read(2'd1);
        check("e3_keep_a1", rd3, 4'hC);
        do_read(2'd2);
        check("e3_keep_a2", rd3, 4'hA);
        do_read(2'd3);
        check("e3_illegal_rv", rv3, 1);
        check("e3_illegal_rd", rd3, 0);
        check("e4_a3_legal", rd0, 4'h7);

`ifdef BSG_MEM_1R1W_WMASK_EN
        do_write(2'd0, 4'hF);
        w_mask = 4'h5;
        do_write(2'd0, 4'h0);
        w_mask = 4'hF;
        do_read(2'd0);
        check("mask_merge_rf", rd0, 4'hA);
        check("mask_merge_wf", rd1, 4'hA);
`endif

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("midclear_ready", rdy0, 0);
        reset = 1'b1;
        tick();
        check("midclear_reset_ready", rdy0, 0);
        check("midclear_reset_rv", rv0, 0);
        check("midclear_reset_rd", rd0, 0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("reclear_ready_c%0d", i), rdy0, (i == 4));
        end
        for (int i = 0; i < 4; i++) begin
            do_read(2'(i));
            check($sformatf("reclear_rd_a%0d", i), rd0, 0);
            check($sformatf("reclear_rd_wf_a%0d", i), rd1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
